// File: rtl/alu_seq_pkg.sv
// Shared encodings for alu_seq_ctrl: request opcodes, external ALU control codes and FSM states.
// The multiplier states exist only when ALU_SEQ_MUL_EN is defined.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_SLT = 3'd4,
    OP_SLL = 3'd5,
    OP_SRL = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  localparam logic [3:0] ALU_NOP  = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b1000;
  localparam logic [3:0] ALU_SUB  = 4'b1001;
  localparam logic [3:0] ALU_AND  = 4'b1100;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b1111;
  localparam logic [3:0] ALU_SLL1 = 4'b1011;
  localparam logic [3:0] ALU_SRL1 = 4'b1010;

  localparam logic [4:0] MUL_LAST_ITER = 5'd31;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXEC    = 3'd1,
    ST_SHIFT   = 3'd2,
`ifdef ALU_SEQ_MUL_EN
    ST_MUL_ADD = 3'd4,
    ST_MUL_SHL = 3'd5,
`endif
    ST_DONE    = 3'd3
  } state_e;

  // ALU control code for the single-cycle operations; anything else leaves the ALU idle.
  function automatic logic [3:0] op_alu_ctrl(input logic [2:0] op);
    logic [3:0] ctrl;
    case (op)
      OP_ADD:  ctrl = ALU_ADD;
      OP_SUB:  ctrl = ALU_SUB;
      OP_AND:  ctrl = ALU_AND;
      OP_OR:   ctrl = ALU_OR;
      OP_SLT:  ctrl = ALU_SLT;
      default: ctrl = ALU_NOP;
    endcase
    return ctrl;
  endfunction

  function automatic logic is_shift_op(input logic [2:0] op);
    return (op == OP_SLL) || (op == OP_SRL);
  endfunction

  function automatic logic is_zero(input logic [31:0] v);
    return (v == 32'd0);
  endfunction

endpackage

// File: rtl/alu_seq_ctrl.sv
// Request/response sequencer that drives an external shared ALU for arithmetic, iterative
// 1-bit shifts and (with ALU_SEQ_MUL_EN defined) a 32-iteration shift-add multiply.
module alu_seq_ctrl
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_shamt,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_flag,
  output logic        rsp_err,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] work_q, work_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_flag_q, rsp_flag_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] result_s;
`ifdef ALU_SEQ_MUL_EN
  logic [31:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [4:0]  iter_q, iter_d;
`endif

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flag  = rsp_flag_q;
  assign rsp_err   = rsp_err_q;

  // Next-state, working-register updates and ALU drive, all decoded from the current state.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_flag_d  = rsp_flag_q;
    rsp_err_d   = rsp_err_q;
    result_s    = 32'd0;
    alu_ctrl    = ALU_NOP;
    alu_a       = 32'd0;
    alu_b       = 32'd0;
`ifdef ALU_SEQ_MUL_EN
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    iter_d      = iter_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d   = req_op;
          a_d    = req_a;
          b_d    = req_b;
          work_d = req_a;
          cnt_d  = req_shamt;
          if (is_shift_op(req_op) && (req_shamt != 5'd0)) begin
            state_d = ST_SHIFT;
`ifdef ALU_SEQ_MUL_EN
          end else if (req_op == OP_MUL) begin
            state_d  = ST_MUL_ADD;
            acc_d    = 32'd0;
            mcand_d  = req_a;
            mplier_d = req_b;
            iter_d   = 5'd0;
`endif
          end else begin
            state_d = ST_EXEC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        // Shift-by-zero and a disabled multiply pass through here without touching the ALU.
        if (op_q <= OP_SLT) begin
          alu_ctrl  = op_alu_ctrl(op_q);
          alu_a     = a_q;
          alu_b     = b_q;
          result_s  = (op_q == OP_SLT) ? {31'd0, alu_zero} : alu_out;
          rsp_err_d = 1'b0;
        end else if (is_shift_op(op_q)) begin
          result_s  = a_q;
          rsp_err_d = 1'b0;
        end else begin
          result_s  = 32'd0;
          rsp_err_d = 1'b1;
        end
        rsp_data_d  = result_s;
        rsp_flag_d  = is_zero(result_s);
        rsp_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_SHIFT: begin
        alu_ctrl = (op_q == OP_SLL) ? ALU_SLL1 : ALU_SRL1;
        alu_b    = work_q;
        work_d   = alu_out;
        cnt_d    = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          rsp_data_d  = alu_out;
          rsp_flag_d  = is_zero(alu_out);
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      ST_MUL_ADD: begin
        alu_ctrl = ALU_ADD;
        alu_a    = acc_q;
        alu_b    = mcand_q;
        if (mplier_q[0]) begin
          acc_d = alu_out;
        end else begin
          acc_d = acc_q;
        end
        state_d = ST_MUL_SHL;
      end
      ST_MUL_SHL: begin
        alu_ctrl = ALU_SLL1;
        alu_b    = mcand_q;
        mcand_d  = alu_out;
        mplier_d = {1'b0, mplier_q[31:1]};
        if (iter_q == MUL_LAST_ITER) begin
          rsp_data_d  = acc_q;
          rsp_flag_d  = is_zero(acc_q);
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          iter_d  = iter_q + 5'd1;
          state_d = ST_MUL_ADD;
        end
      end
`endif
      ST_DONE: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State, captured request and response registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= 3'd0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      work_q      <= 32'd0;
      cnt_q       <= 5'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_flag_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      acc_q       <= 32'd0;
      mcand_q     <= 32'd0;
      mplier_q    <= 32'd0;
      iter_q      <= 5'd0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flag_q  <= rsp_flag_d;
      rsp_err_q   <= rsp_err_d;
`ifdef ALU_SEQ_MUL_EN
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      iter_q      <= iter_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl with a behavioural model of the external ALU.
// Multiply expectations follow ALU_SEQ_MUL_EN, matching the build of the design.
module tb_alu_seq_ctrl;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic [4:0]  req_shamt = 5'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_flag;
  logic        rsp_err;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic        busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    logic        flag;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  alu_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flag(rsp_flag), .rsp_err(rsp_err),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero), .busy(busy)
  );

  // External ALU: on SLT its zero flag reports the signed less-than outcome.
  always_comb begin
    alu_out = 32'd0;
    case (alu_ctrl)
      4'b1000: alu_out = alu_a + alu_b;
      4'b1001: alu_out = alu_a - alu_b;
      4'b1100: alu_out = alu_a & alu_b;
      4'b0100: alu_out = alu_a | alu_b;
      4'b1111: alu_out = {31'd0, ($signed(alu_a) < $signed(alu_b))};
      4'b1011: alu_out = alu_b << 1;
      4'b1010: alu_out = alu_b >> 1;
      default: alu_out = 32'd0;
    endcase
    alu_zero = (alu_ctrl == 4'b1111) ? alu_out[0] : (alu_out == 32'd0);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic exp_t ref_model(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b, input logic [4:0] sh);
    exp_t e;
    e.data = 32'd0;
    e.err  = 1'b0;
    e.lat  = 2;
    case (op)
      3'd0: e.data = a + b;
      3'd1: e.data = a - b;
      3'd2: e.data = a & b;
      3'd3: e.data = a | b;
      3'd4: e.data = {31'd0, ($signed(a) < $signed(b))};
      3'd5: begin e.data = a << sh; e.lat = (sh == 5'd0) ? 2 : int'(sh) + 1; end
      3'd6: begin e.data = a >> sh; e.lat = (sh == 5'd0) ? 2 : int'(sh) + 1; end
      3'd7: begin
`ifdef ALU_SEQ_MUL_EN
        e.data = a * b;
        e.lat  = 65;
`else
        e.data = 32'd0;
        e.err  = 1'b1;
`endif
      end
      default: e.data = 32'd0;
    endcase
    e.flag = (e.data == 32'd0);
    return e;
  endfunction

  // Drive one request, log its expectation, then hold garbage on req_* while busy.
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] sh);
    @(negedge clk);
    req_op = op; req_a = a; req_b = b; req_shamt = sh; req_valid = 1'b1;
    check_val("req_ready_idle", 32'(req_ready), 32'd1);
    sb_q.push_back(ref_model(op, a, b, sh));
    @(posedge clk);
    #1;
    req_a = $urandom(); req_b = $urandom();
    req_op = 3'($urandom_range(0, 7)); req_shamt = 5'($urandom_range(0, 31));
    check_val("busy_after_accept", 32'(busy), 32'd1);
  endtask

  // Wait for the response, compare against the scoreboard head, optionally stall, then release.
  task automatic get_rsp(input int hold);
    exp_t e;
    int k;
    e = sb_q.pop_front();
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!rsp_valid && k < 200);
    check_val("rsp_latency", 32'(k), 32'(e.lat));
    if (rsp_valid) begin
      check_val("rsp_data", rsp_data, e.data);
      check_val("rsp_flag", 32'(rsp_flag), 32'(e.flag));
      check_val("rsp_err", 32'(rsp_err), 32'(e.err));
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check_val("bp_valid", 32'(rsp_valid), 32'd1);
        check_val("bp_data", rsp_data, e.data);
        check_val("bp_req_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      check_val("release_idle", 32'(busy), 32'd0);
      check_val("release_valid", 32'(rsp_valid), 32'd0);
      req_valid = 1'b0;
    end else begin
      req_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1);
  end

  initial begin
    logic saw;
    repeat (2) @(negedge clk);
    check_val("rst_req_ready", 32'(req_ready), 32'd1);
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    check_val("rst_rsp_data", rsp_data, 32'd0);
    rst_n = 1'b1;

    send(3'd0, 32'd5, 32'd7, 5'd0);                 get_rsp(0);
    send(3'd1, 32'd9, 32'd9, 5'd0);                 get_rsp(0);
    send(3'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0); get_rsp(0);
    send(3'd3, 32'h1200_0000, 32'h0000_0034, 5'd0); get_rsp(0);
    send(3'd4, 32'd3, 32'd5, 5'd0);                 get_rsp(0);
    send(3'd4, 32'd5, 32'd3, 5'd0);                 get_rsp(0);
    send(3'd4, 32'hFFFF_FFFF, 32'd1, 5'd0);         get_rsp(0);
    send(3'd6, 32'h8000_0000, 32'd0, 5'd31);        get_rsp(0);
    send(3'd5, 32'h0000_00A5, 32'd0, 5'd0);         get_rsp(0);
    send(3'd5, 32'h1234_5678, 32'd0, 5'd4);         get_rsp(0);
    send(3'd6, 32'h0000_00F0, 32'd0, 5'd1);         get_rsp(0);
    send(3'd5, 32'h0000_0001, 32'd0, 5'd1);         get_rsp(0);
    send(3'd7, 32'd7, 32'd6, 5'd0);                 get_rsp(0);
`ifdef ALU_SEQ_MUL_EN
    send(3'd7, 32'h0001_0000, 32'h0001_0000, 5'd0); get_rsp(0);
    send(3'd7, 32'hFFFF_FFFF, 32'd3, 5'd0);         get_rsp(0);
`endif

    send(3'd0, 32'd100, 32'd23, 5'd0);              get_rsp(10);

    // Reset in the middle of a long operation; the abandoned request leaves the scoreboard.
`ifdef ALU_SEQ_MUL_EN
    send(3'd7, 32'd7, 32'd6, 5'd0);
`else
    send(3'd6, 32'h8000_0000, 32'd0, 5'd31);
`endif
    req_valid = 1'b0;
    repeat (19) @(negedge clk);
    check_val("busy_before_rst", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    sb_q.delete(0);
    check_val("midrst_busy", 32'(busy), 32'd0);
    check_val("midrst_req_ready", 32'(req_ready), 32'd1);
    check_val("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("midrst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    check_val("midrst_alu_a", alu_a, 32'd0);
    check_val("midrst_alu_b", alu_b, 32'd0);
    check_val("midrst_rsp_data", rsp_data, 32'd0);
    check_val("midrst_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (rsp_valid || busy) saw = 1'b1;
    end
    check_val("no_rsp_after_rst", 32'(saw), 32'd0);

    send(3'd0, 32'hFFFF_FFFF, 32'd1, 5'd0);         get_rsp(0);
    send(3'd0, 32'd5, 32'd7, 5'd0);                 get_rsp(0);

    check_val("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have clk  in  1  sole clock; all state on rising edge.
REQ-002 SHALL have rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have req_valid in 1, req_ready out 1, req_op in 3 (0 ADD,1 SUB,2 AND,3 OR,4 SLT,5 SLL,6 SRL,7 MUL), req_a in 32, req_b in 32, req_shamt in 5.
REQ-004 SHALL have rsp_valid out 1, rsp_ready in 1, rsp_data out 32, rsp_flag out 1 (rsp_data==0), rsp_err out 1 (illegal op).
REQ-005 SHALL have alu_ctrl out 4, alu_a out 32, alu_b out 32, alu_out in 32, alu_zero in 1 (external shared ALU), busy out 1 (state != IDLE).

Function
REQ-006 SHALL accept a request only on a clk edge with req_valid && req_ready; req_ready = (state==IDLE); operands/op/shamt captured into registers at acceptance.
REQ-007 SHALL implement states IDLE, EXEC, SHIFT, MUL_ADD, MUL_SHL, DONE.
REQ-008 SHALL map ALU codes: ADD 1000, SUB 1001, AND 1100, OR 0100, SLT 1111, SLL1 1011, SRL1 1010; outside EXEC/SHIFT/MUL states drive alu_ctrl=0000, alu_a=alu_b=0.
REQ-009 SHALL, for ops 0-4: IDLE->EXEC (one cycle, alu_a=A, alu_b=B) ->DONE; rsp_valid high 2 cycles after acceptance edge.
REQ-010 SHALL, for SLT, set rsp_data={31'b0, alu_zero}, alu_out ignored.
REQ-011 SHALL, for SLL/SRL with shamt N>0: SHIFT for N cycles, alu_b=work register (init A), work<=alu_out each cycle; rsp_valid at N+1 cycles after acceptance.
REQ-012 SHALL, for shamt N=0, go EXEC-equivalent one cycle with no ALU use and return A; latency 2.
REQ-013 SHALL, for MUL, run 32 iterations of MUL_ADD then MUL_SHL (64 cycles): MUL_ADD drives ADD acc+mcand, acc updated only if multiplier bit0=1; MUL_SHL drives SLL1 on mcand, multiplier shifted right internally; rsp_data=low 32 bits of A*B; latency 65.
REQ-014 SHALL hold rsp_valid and all rsp_* stable in DONE until rsp_ready; DONE->IDLE on the edge where rsp_ready=1; no new acceptance in that same edge.
REQ-015 SHALL compute rsp_flag from final rsp_data for every op.
REQ-016 SHALL ignore req_* changes while busy.

Reset
REQ-017 SHALL on rst_n low, immediately: state=IDLE, req_ready=1 (after state settles), rsp_valid=0, rsp_data=0, rsp_flag=0, rsp_err=0, busy=0, alu_ctrl=0000, alu_a=alu_b=0, all working registers 0.
REQ-018 SHALL abandon any in-progress operation on reset with no response produced.

Configuration
REQ-019 SHALL with ALU_SEQ_MUL_EN defined implement MUL per REQ-013.
REQ-020 SHALL without ALU_SEQ_MUL_EN omit MUL_ADD/MUL_SHL and multiplier registers; op 7 goes EXEC->DONE with rsp_data=0, rsp_flag=1, rsp_err=1, latency 2, no ALU use.

Structure
REQ-021 SHALL place op encodings, ALU control constants and state encodings in shared package alu_seq_pkg.
REQ-022 SHALL be a single module; ALU stays external so it can be shared; no sub-module.

Verification
REQ-023 ADD A=5,B=7 -> rsp_valid 2 cycles after accept, rsp_data=12, flag=0; SLT A=3,B=5 (alu_zero=1) -> rsp_data=1.
REQ-024 SRL A=0x80000000 shamt=31 -> rsp_data=1 at cycle 32; SLL shamt=0 A=0xA5 -> 0xA5 at cycle 2.
REQ-025 MUL A=7,B=6 -> rsp_data=42 at cycle 65; A=B=0x10000 -> rsp_data=0, rsp_flag=1.
REQ-026 Backpressure: rsp_ready low 10 cycles after ADD -> rsp stable, req_ready=0 throughout; release -> IDLE next edge.
REQ-027 rst_n low mid-MUL (cycle 20) -> outputs per REQ-017 immediately, no rsp_valid after release; next ADD completes normally.
REQ-028 Without ALU_SEQ_MUL_EN: op 7 -> rsp_err=1, rsp_data=0 at cycle 2.
